// File: rtl/cameralink_frame_gen.sv
// cameralink_frame_gen: CameraLink camera-side frame/line timing and RGB test-pattern generator.
// Optional macro CAMERALINK_PIXEL_GAP_EN: VCE toggles every clock within a line, so each line lasts 2*WIDTH clocks.
module cameralink_frame_gen #(
  parameter int WIDTH    = 16,
  parameter int HEIGHT   = 8,
  parameter int VSETUP   = 2,
  parameter int HBLANK   = 4,
  parameter int FGAP     = 3,
  parameter int FREE_RUN = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cam_enable,
  input  logic        cam_request,
  output logic [26:0] data_o,
  output logic        busy,
  output logic [15:0] frame_count
);
  typedef enum logic [2:0] {IDLE, FSTART, LINE, HBLK, FEND} state_t;
  localparam logic [15:0] W1  = 16'(WIDTH - 1);
  localparam logic [15:0] H1  = 16'(HEIGHT - 1);
  localparam logic [15:0] VS1 = 16'(VSETUP - 1);
  localparam logic [15:0] HB1 = 16'(HBLANK - 1);
  localparam logic [15:0] FG1 = 16'(FGAP - 1);
  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d, fc_q, fc_d;
  logic [26:0] data_q, data_d;
  logic        req_q, pend_q, pend_d, ph_q, ph_d, busy_q;
  logic        edge_w, step, last_px, lvv, vce;
  always_comb begin
    edge_w = cam_request && !req_q;
`ifdef CAMERALINK_PIXEL_GAP_EN
    step = ph_q;
`else
    step = 1'b1;
`endif
    last_px = step && (x_q == W1);
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    cnt_d = cnt_q + 16'd1;
    ph_d = 1'b0;
    fc_d = fc_q;
    pend_d = pend_q || (edge_w && state_q != IDLE);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_w && cam_enable) state_d = FSTART;
      end
      FSTART: if (cnt_q == VS1) begin
        state_d = LINE;
        cnt_d = '0;
        x_d = '0;
        y_d = '0;
      end
      LINE: begin
        cnt_d = '0;
        ph_d = !ph_q;
        x_d = step ? x_q + 16'd1 : x_q;
        if (last_px) begin
          x_d = '0;
          ph_d = 1'b0;
          state_d = (y_q == H1) ? FEND : HBLK;
          y_d = (y_q == H1) ? '0 : y_q + 16'd1;
          fc_d = (y_q == H1) ? fc_q + 16'd1 : fc_q;
        end
      end
      HBLK: if (cnt_q == HB1) begin
        state_d = LINE;
        cnt_d = '0;
      end
      FEND: if (cnt_q == FG1) begin
        cnt_d = '0;
        pend_d = 1'b0;
        state_d = (pend_q || edge_w || (FREE_RUN != 0 && cam_enable)) ? FSTART : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // losing enable mid-frame aborts everything, even a same-cycle trigger
    if (state_q != IDLE && !cam_enable) begin
      state_d = IDLE;
      pend_d = 1'b0;
      x_d = '0;
      y_d = '0;
      cnt_d = '0;
      ph_d = 1'b0;
      fc_d = fc_q;
    end
    lvv = state_d == LINE;
`ifdef CAMERALINK_PIXEL_GAP_EN
    vce = lvv && !ph_d;
`else
    vce = lvv;
`endif
    data_d = {state_d != IDLE && state_d != FEND, lvv, vce,
              lvv ? {fc_d[7:0], y_d[7:0], x_d[7:0]} : 24'd0};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      fc_q <= '0;
      data_q <= '0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      ph_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
      fc_q <= fc_d;
      data_q <= data_d;
      req_q <= cam_request;
      pend_q <= pend_d;
      ph_q <= ph_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign data_o = data_q;
  assign busy = busy_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_cameralink_frame_gen.sv
// tb_cameralink_frame_gen: randomized checks of frame timing against a per-frame expected word stream.
module tb_cameralink_frame_gen;
  localparam int W = 4, H = 2, VS = 2, HB = 3, FG = 2, WB = 300;
`ifdef CAMERALINK_PIXEL_GAP_EN
  localparam int PX = 2;
`else
  localparam int PX = 1;
`endif
  localparam int LW = W * PX;
  logic clock = 1'b0, reset = 1'b1;
  logic en_a = 1'b0, req_a = 1'b0, en_b = 1'b0, req_b = 1'b0;
  logic [26:0] data_a, data_b;
  logic        busy_a, busy_b;
  logic [15:0] fc_a, fc_b;
  logic [26:0] exp_q[$];
  int n_checks = 0, n_fail = 0, fc_model = 0;
  always #5 clock = ~clock;
  cameralink_frame_gen #(.WIDTH(W), .HEIGHT(H), .VSETUP(VS), .HBLANK(HB), .FGAP(FG), .FREE_RUN(0)) dut_a (
    .clock(clock), .reset(reset), .cam_enable(en_a), .cam_request(req_a),
    .data_o(data_a), .busy(busy_a), .frame_count(fc_a));
  cameralink_frame_gen #(.WIDTH(WB), .HEIGHT(H), .VSETUP(VS), .HBLANK(HB), .FGAP(FG), .FREE_RUN(1)) dut_b (
    .clock(clock), .reset(reset), .cam_enable(en_b), .cam_request(req_b),
    .data_o(data_b), .busy(busy_b), .frame_count(fc_b));
  // expected data_o for every FVV-high cycle of one frame, from the frame layout rules
  task automatic build_frame(input int w, input int fc);
    logic [7:0] r, g, b;
    exp_q.delete();
    repeat (VS) exp_q.push_back(27'h4000000);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < w; x++) begin
        r = 8'(x);
        g = 8'(y);
        b = 8'(fc);
        exp_q.push_back({3'b111, b, g, r});
        if (PX == 2) exp_q.push_back({3'b110, b, g, r});
      end
      if (y < H - 1) repeat (HB) exp_q.push_back(27'h4000000);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({data_a, busy_a, fc_a, data_b, busy_b, fc_b} !== 88'd0) begin
      n_fail++;
      $display("FAIL reset_state: a=%h/%b/%0d b=%h/%b/%0d expected all 0", data_a, busy_a, fc_a, data_b, busy_b, fc_b);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      req_a = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1));
      @(negedge clock);
      n_checks++;
      if ({data_a, busy_a, fc_a, data_b, busy_b, fc_b} !== 88'd0) begin
        n_fail++;
        $display("FAIL disabled_idle[%0d]: a=%h/%b/%0d b=%h/%b/%0d expected all 0", i, data_a, busy_a, fc_a, data_b, busy_b, fc_b);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_single_frame;
    int plen;
    en_a = 1'b1;
    repeat ($urandom_range(1, 5)) @(negedge clock);
    build_frame(W, fc_model);
    plen = $urandom_range(1, 5);
    req_a = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i + 1 >= plen) req_a = 1'b0;
      n_checks++;
      if (data_a !== exp_q[i] || busy_a !== 1'b1 || fc_a !== 16'(fc_model)) begin
        n_fail++;
        $display("FAIL single_frame[%0d]: data=%h busy=%b fc=%0d expected %h 1 %0d", i, data_a, busy_a, fc_a, exp_q[i], fc_model);
      end
    end
    fc_model++;
    for (int i = 0; i < FG; i++) begin
      @(negedge clock);
      n_checks++;
      if (data_a !== 27'd0 || busy_a !== 1'b1 || fc_a !== 16'(fc_model)) begin
        n_fail++;
        $display("FAIL single_fend[%0d]: data=%h busy=%b fc=%0d expected 0 1 %0d", i, data_a, busy_a, fc_a, fc_model);
      end
    end
    @(negedge clock);
    n_checks++;
    if (data_a !== 27'd0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: data=%h busy=%b expected 0 0", data_a, busy_a);
    end
  endtask
  task automatic test_back_to_back;
    int k1, k2;
    k1 = $urandom_range(VS, VS + LW - 1);
    k2 = VS + LW + HB - 1;
    build_frame(W, fc_model);
    req_a = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      req_a = (i == k1 || i == k2);
      n_checks++;
      if (data_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_first[%0d]: data=%h expected %h", i, data_a, exp_q[i]);
      end
    end
    req_a = 1'b0;
    fc_model++;
    for (int i = 0; i < FG; i++) begin
      @(negedge clock);
      n_checks++;
      if (data_a !== 27'd0 || busy_a !== 1'b1 || fc_a !== 16'(fc_model)) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: data=%h busy=%b fc=%0d expected 0 1 %0d", i, data_a, busy_a, fc_a, fc_model);
      end
    end
    build_frame(W, fc_model);
    foreach (exp_q[i]) begin
      @(negedge clock);
      n_checks++;
      if (data_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_second[%0d]: data=%h expected %h", i, data_a, exp_q[i]);
      end
    end
    fc_model++;
    repeat (FG) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_checks++;
      if (data_a !== 27'd0 || busy_a !== 1'b0 || fc_a !== 16'(fc_model)) begin
        n_fail++;
        $display("FAIL b2b_depth[%0d]: data=%h busy=%b fc=%0d expected 0 0 %0d", i, data_a, busy_a, fc_a, fc_model);
      end
    end
  endtask
  task automatic test_abort;
    int drop;
    logic with_edge;
    drop = $urandom_range(VS + LW, VS + LW + HB - 1);
    with_edge = 1'($urandom_range(0, 1));
    build_frame(W, fc_model);
    req_a = 1'b1;
    for (int i = 0; i <= drop; i++) begin
      @(negedge clock);
      req_a = 1'b0;
      n_checks++;
      if (data_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_pre[%0d]: data=%h expected %h", i, data_a, exp_q[i]);
      end
    end
    en_a = 1'b0;
    req_a = with_edge;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      req_a = 1'b0;
      if (i == 2) en_a = 1'b1;
      n_checks++;
      if (data_a !== 27'd0 || busy_a !== 1'b0 || fc_a !== 16'(fc_model)) begin
        n_fail++;
        $display("FAIL abort_idle[%0d]: data=%h busy=%b fc=%0d expected 0 0 %0d", i, data_a, busy_a, fc_a, fc_model);
      end
    end
    build_frame(W, fc_model);
    req_a = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      req_a = 1'b0;
      n_checks++;
      if (data_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_fresh[%0d]: data=%h expected %h", i, data_a, exp_q[i]);
      end
    end
    fc_model++;
    @(negedge clock);
    n_checks++;
    if (data_a !== 27'd0 || fc_a !== 16'(fc_model)) begin
      n_fail++;
      $display("FAIL abort_count: data=%h fc=%0d expected 0 %0d", data_a, fc_a, fc_model);
    end
  endtask
  task automatic test_free_run;
    en_b = 1'b1;
    req_b = 1'b1;
    for (int f = 0; f < 3; f++) begin
      build_frame(WB, f);
      foreach (exp_q[i]) begin
        @(negedge clock);
        req_b = 1'b0;
        n_checks++;
        if (data_b !== exp_q[i]) begin
          n_fail++;
          $display("FAIL free_run_f%0d[%0d]: data=%h expected %h", f, i, data_b, exp_q[i]);
        end
      end
      for (int i = 0; i < FG; i++) begin
        @(negedge clock);
        n_checks++;
        if (data_b !== 27'd0 || busy_b !== 1'b1 || fc_b !== 16'(f + 1)) begin
          n_fail++;
          $display("FAIL free_run_gap_f%0d[%0d]: data=%h busy=%b fc=%0d expected 0 1 %0d", f, i, data_b, busy_b, fc_b, f + 1);
        end
      end
    end
    en_b = 1'b0;
    @(negedge clock);
    n_checks++;
    if (data_b !== 27'd0 || busy_b !== 1'b0 || fc_b !== 16'd3) begin
      n_fail++;
      $display("FAIL free_run_stop: data=%h busy=%b fc=%0d expected 0 0 3", data_b, busy_b, fc_b);
    end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_free_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
